// File: rtl/chain_score_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : chain_pkg
// Purpose  : Shared types and defaults for the chaining-score scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package chain_pkg;

    localparam int c_SCORE_LAT = 5;
    localparam int c_MAX_PRED  = 64;
    localparam int c_IDX_W     = 16;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE  = 3'd0;
    localparam state_t c_ST_LOAD  = 3'd1;
    localparam state_t c_ST_ISSUE = 3'd2;
    localparam state_t c_ST_DRAIN = 3'd3;
    localparam state_t c_ST_DONE  = 3'd4;

    // One in-flight (i, j) pair travelling alongside the score pipeline.
    typedef struct packed {
        logic               valid;
        logic [c_IDX_W-1:0] idx;
        logic [31:0]        f;
        logic               ok;
    } tag_t;

endpackage
`default_nettype wire

// File: rtl/chain_score_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : chain_score_scheduler_if
// Purpose  : Job, anchor-RAM, score-pipeline and result signals of the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface chain_score_scheduler_if #(
    parameter int IDX_W  = 16,
    parameter int PRED_W = 7
);
    logic              start;
    logic [IDX_W-1:0]  anchor_i;
    logic [PRED_W-1:0] n_pred;
    logic [31:0]       w_self;
    logic [31:0]       cfg_max_dist;
    logic [31:0]       cfg_w_avg;
    logic              busy;

    logic              ram_rd;
    logic [IDX_W-1:0]  ram_addr;
    logic [31:0]       ram_rx;
    logic [31:0]       ram_qy;
    logic [31:0]       ram_f;

    logic [31:0]       sc_riX;
    logic [31:0]       sc_riY;
    logic [31:0]       sc_qiX;
    logic [31:0]       sc_qiY;
    logic [31:0]       sc_W;
    logic [31:0]       sc_Wavg;
    logic [31:0]       sc_result;

    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_f;
    logic [IDX_W-1:0]  out_p;
    logic              out_p_valid;

    modport master (
        input  start, anchor_i, n_pred, w_self, cfg_max_dist, cfg_w_avg,
               ram_rx, ram_qy, ram_f, sc_result, out_ready,
        output busy, ram_rd, ram_addr, sc_riX, sc_riY, sc_qiX, sc_qiY,
               sc_W, sc_Wavg, out_valid, out_f, out_p, out_p_valid
    );

    modport slave (
        output start, anchor_i, n_pred, w_self, cfg_max_dist, cfg_w_avg,
               ram_rx, ram_qy, ram_f, sc_result, out_ready,
        input  busy, ram_rd, ram_addr, sc_riX, sc_riY, sc_qiX, sc_qiY,
               sc_W, sc_Wavg, out_valid, out_f, out_p, out_p_valid
    );

endinterface
`default_nettype wire

// File: rtl/chain_score_scheduler_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : chain_tag_pipe
// Purpose  : Fixed-depth tag shift register matching the score pipeline latency.
// Revision : 1.0 - initial release
// ============================================================================
module chain_tag_pipe
    import chain_pkg::*;
#(
    parameter int DEPTH = c_SCORE_LAT
) (
    input  logic clk,
    input  logic reset,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_pending
);

    tag_t r_stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= tag_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    // Excludes the exiting stage: that entry is collected on the current edge.
    always_comb begin
        any_pending = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            any_pending = any_pending | r_stage[k].valid;
        end
    end

    assign tag_out = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/chain_score_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : chain_score_scheduler
// Purpose  : Feeds (i, j) pairs to the score pipeline and returns f[i] / p[i].
// Revision : 1.0 - initial release
// ============================================================================
module chain_score_scheduler
    import chain_pkg::*;
#(
    parameter int IDX_W     = 16,
    parameter int PRED_W    = 7,
    parameter int MAX_PRED  = c_MAX_PRED,
    parameter int SCORE_LAT = c_SCORE_LAT
) (
    input  logic                    clk,
    input  logic                    reset,
    chain_score_scheduler_if.master bus
);

    localparam int c_CNT_W = $clog2(MAX_PRED + 1);

    function automatic logic [c_CNT_W-1:0] f_n_eff(input logic [PRED_W-1:0] np,
                                                   input logic [IDX_W-1:0]  ai);
        logic [31:0] m;
        m = 32'(np);
        if (m > 32'(MAX_PRED)) m = 32'(MAX_PRED);
        if (m > 32'(ai))       m = 32'(ai);
        return c_CNT_W'(m);
    endfunction

    state_t             r_state;
    logic [IDX_W-1:0]   r_anchor;
    logic [IDX_W-1:0]   r_addr;
    logic [c_CNT_W-1:0] r_left;
    logic [31:0]        r_w_self;
    logic               r_self_rd;
    logic               r_pair_rd;
    logic [IDX_W-1:0]   r_pair_idx;
    logic [31:0]        r_rx_i;
    logic [31:0]        r_qy_i;
    logic [31:0]        r_best_f;
    logic [IDX_W-1:0]   r_best_p;
    logic               r_p_valid;

    logic               w_pair_ok;
    logic               w_pending;
    logic [31:0]        w_cand;
    logic               w_better;
    tag_t               w_tag_in;
    tag_t               w_tag_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_anchor <= '0;
            r_addr   <= '0;
            r_left   <= '0;
            r_w_self <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_anchor <= bus.anchor_i;
                        r_left   <= f_n_eff(bus.n_pred, bus.anchor_i);
                        r_w_self <= bus.w_self;
                        r_state  <= c_ST_LOAD;
                    end
                end
                c_ST_LOAD: begin
                    r_addr  <= r_anchor - IDX_W'(1);
                    r_state <= (r_left == '0) ? c_ST_DONE : c_ST_ISSUE;
                end
                c_ST_ISSUE: begin
                    r_addr <= r_addr - IDX_W'(1);
                    r_left <= r_left - c_CNT_W'(1);
                    if (r_left == c_CNT_W'(1)) begin
                        r_state <= c_ST_DRAIN;
                    end
                end
                c_ST_DRAIN: begin
                    if (!r_pair_rd && !w_pending) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // RAM data lags the read by one cycle; these flags mark what is arriving.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_self_rd  <= 1'b0;
            r_pair_rd  <= 1'b0;
            r_pair_idx <= '0;
            r_rx_i     <= '0;
            r_qy_i     <= '0;
        end else begin
            r_self_rd  <= (r_state == c_ST_LOAD);
            r_pair_rd  <= (r_state == c_ST_ISSUE);
            r_pair_idx <= r_addr;
            if (r_self_rd) begin
                r_rx_i <= bus.ram_rx;
                r_qy_i <= bus.ram_qy;
            end
        end
    end

    assign w_pair_ok = (bus.ram_rx < r_rx_i) && (bus.ram_qy < r_qy_i) &&
                       ((r_rx_i - bus.ram_rx) <= bus.cfg_max_dist);

    always_comb begin
        w_tag_in       = '0;
        w_tag_in.valid = r_pair_rd;
        w_tag_in.idx   = c_IDX_W'(r_pair_idx);
        w_tag_in.f     = bus.ram_f;
        w_tag_in.ok    = w_pair_ok;
    end

    chain_tag_pipe #(
        .DEPTH       (SCORE_LAT)
    ) u_tag_pipe (
        .clk         (clk),
        .reset       (reset),
        .tag_in      (w_tag_in),
        .tag_out     (w_tag_out),
        .any_pending (w_pending)
    );

    // Strict compare so an equal later (farther) candidate never displaces a nearer one.
    assign w_cand   = w_tag_out.f + bus.sc_result;
    assign w_better = w_tag_out.valid && w_tag_out.ok &&
                      ($signed(w_cand) > $signed(r_best_f));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_best_f  <= '0;
            r_best_p  <= '0;
            r_p_valid <= 1'b0;
        end else if (r_state == c_ST_LOAD) begin
            r_best_f  <= r_w_self;
            r_best_p  <= '0;
            r_p_valid <= 1'b0;
        end else if (w_better) begin
            r_best_f  <= w_cand;
            r_best_p  <= IDX_W'(w_tag_out.idx);
            r_p_valid <= 1'b1;
        end
    end

    assign bus.busy     = (r_state != c_ST_IDLE);
    assign bus.ram_rd   = (r_state == c_ST_LOAD) || (r_state == c_ST_ISSUE);
    assign bus.ram_addr = (r_state == c_ST_LOAD)  ? r_anchor :
                          (r_state == c_ST_ISSUE) ? r_addr   : '0;

    assign bus.sc_riX   = r_pair_rd ? r_rx_i        : '0;
    assign bus.sc_riY   = r_pair_rd ? bus.ram_rx    : '0;
    assign bus.sc_qiX   = r_pair_rd ? r_qy_i        : '0;
    assign bus.sc_qiY   = r_pair_rd ? bus.ram_qy    : '0;
    assign bus.sc_W     = r_pair_rd ? r_w_self      : '0;
    assign bus.sc_Wavg  = r_pair_rd ? bus.cfg_w_avg : '0;

    assign bus.out_valid   = (r_state == c_ST_DONE);
    assign bus.out_f       = r_best_f;
    assign bus.out_p       = r_best_p;
    assign bus.out_p_valid = r_p_valid;

endmodule
`default_nettype wire
